id_ex_decode_stage: RTL

//  Decode stage and ID/EX pipeline register. Turns a 32-bit instruction into the 5-bit ALU OP code
//  and the signed A/B operands that the ALU consumes.

---
 rtl/cpu_pkg.sv | 60 ++++++
 rtl/instr_decoder.sv | 63 ++++++
 rtl/id_ex_decode_stage.sv | 109 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared decode definitions: ALU op codes, opcodes, ID/EX word layout.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int N    = 32;   // datapath / operand width, matches the ALU
    localparam int RA_W = 5;    // register address width

    typedef enum logic [4:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_SLA = 5'd7,
        ALU_SRA = 5'd8,
        ALU_LUI = 5'd9,
        ALU_LLI = 5'd10
    } alu_op_e;

    // Highest R-type funct code the ALU implements; anything above is illegal.
    localparam logic [4:0] R_FUNCT_MAX = 5'd8;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b000001;
    localparam logic [5:0] OPC_ANDI  = 6'b000010;
    localparam logic [5:0] OPC_ORI   = 6'b000011;
    localparam logic [5:0] OPC_XORI  = 6'b000100;
    localparam logic [5:0] OPC_LUI   = 6'b001001;
    localparam logic [5:0] OPC_LLI   = 6'b001010;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_HAZ = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      op;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [RA_W-1:0] rd;
        logic            mem_rd;
        logic            mem_wr;
        logic [N-1:0]    st_data;
    } id_ex_t;

    function automatic logic [N-1:0] sext16(input logic [15:0] v);
        return {{(N-16){v[15]}}, v};
    endfunction

    function automatic logic [N-1:0] zext16(input logic [15:0] v);
        return {{(N-16){1'b0}}, v};
    endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one instruction word into an ID/EX word.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides whether the word is used.
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [31:0]     instr,
    input  logic [N-1:0]    rs_data,
    input  logic [N-1:0]    rt_data,
    output logic [RA_W-1:0] rs_addr,
    output logic [RA_W-1:0] rt_addr,
    output id_ex_t          dec,
    output logic            illegal,
    output logic            reads_rt
);

    assign rs_addr = instr[20:16];
    assign rt_addr = instr[15:11];

    // Opcode decode; illegal words come out as a bubble with op forced to ADD.
    always_comb begin
        dec          = '0;
        dec.valid    = 1'b1;
        dec.rd       = instr[25:21];
        dec.a        = rs_data;
        dec.b        = rt_data;
        illegal      = 1'b0;
        reads_rt     = 1'b0;
        case (instr[31:26])
            OPC_RTYPE: begin
                reads_rt = 1'b1;
                if (instr[4:0] > R_FUNCT_MAX) illegal = 1'b1;
                else                          dec.op  = instr[4:0];
            end
            OPC_ADDI: begin dec.op = ALU_ADD; dec.b = sext16(instr[15:0]); end
            OPC_ANDI: begin dec.op = ALU_AND; dec.b = zext16(instr[15:0]); end
            OPC_ORI:  begin dec.op = ALU_OR;  dec.b = zext16(instr[15:0]); end
            OPC_XORI: begin dec.op = ALU_XOR; dec.b = zext16(instr[15:0]); end
            OPC_LUI:  begin dec.op = ALU_LUI; dec.b = zext16(instr[15:0]); end
            OPC_LLI:  begin dec.op = ALU_LLI; dec.b = zext16(instr[15:0]); end
            OPC_LW: begin
                dec.op     = ALU_ADD;
                dec.b      = sext16(instr[15:0]);
                dec.mem_rd = 1'b1;
            end
            OPC_SW: begin
                reads_rt    = 1'b1;
                dec.op      = ALU_ADD;
                dec.b       = sext16(instr[15:0]);
                dec.mem_wr  = 1'b1;
                dec.st_data = rt_data;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            dec.valid  = 1'b0;
            dec.op     = '0;
            dec.mem_rd = 1'b0;
            dec.mem_wr = 1'b0;
        end
    end

endmodule

// File: rtl/id_ex_decode_stage.sv
// Decode stage + ID/EX register with valid/ready, load-use stall, flush, illegal-op pulse.
// Latency: 1 cycle from accepted instr to registered outputs.
// Backpressure: out_ready low holds every output; in_ready drops until the register frees.
module id_ex_decode_stage
    import cpu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic [RA_W-1:0] rs_addr,
    output logic [RA_W-1:0] rt_addr,
    input  logic [N-1:0]    rs_data,
    input  logic [N-1:0]    rt_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [4:0]      op,
    output logic [N-1:0]    a,
    output logic [N-1:0]    b,
    output logic [RA_W-1:0] rd,
    output logic            mem_rd,
    output logic            mem_wr,
    output logic [N-1:0]    st_data,
    output logic            illegal
);

    id_ex_t    q;
    id_ex_t    dec;
    logic      dec_illegal;
    logic      dec_reads_rt;
    logic      advance;
    logic      hazard;
    logic      accept;
    hz_state_e state;
    hz_state_e state_nxt;

    instr_decoder u_dec (
        .instr    (instr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .dec      (dec),
        .illegal  (dec_illegal),
        .reads_rt (dec_reads_rt)
    );

    // Load-use detect against the load sitting in ID/EX; masked in HAZ because
    // the bubble has already given the load its extra cycle.
    always_comb begin
        hazard = (state == ST_RUN) && q.valid && q.mem_rd && (q.rd != '0) && in_valid &&
                 ((q.rd == rs_addr) || ((q.rd == rt_addr) && dec_reads_rt));
    end

    assign advance  = ~q.valid | out_ready;
    assign in_ready = ~flush & advance & ~hazard;
    assign accept   = in_valid & in_ready;

    // Stall FSM next state: flush always returns to RUN.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_RUN;
        end else if (advance) begin
            case (state)
                ST_RUN:  if (hazard) state_nxt = ST_HAZ;
                ST_HAZ:  state_nxt = ST_RUN;
                default: state_nxt = ST_RUN;
            endcase
        end
    end

    // Stall FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    // ID/EX register: load decoded word, insert bubble, or hold under backpressure.
    // Bubbles leave a/b/rd/st_data untouched to avoid needless toggling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            illegal <= 1'b0;
        end else begin
            illegal <= accept & dec_illegal;
            if (flush || (advance && !(accept && !dec_illegal))) begin
                q.valid  <= 1'b0;
                q.op     <= '0;
                q.mem_rd <= 1'b0;
                q.mem_wr <= 1'b0;
            end else if (advance) begin
                q <= dec;
            end
        end
    end

    assign out_valid = q.valid;
    assign op        = q.op;
    assign a         = q.a;
    assign b         = q.b;
    assign rd        = q.rd;
    assign mem_rd    = q.mem_rd;
    assign mem_wr    = q.mem_wr;
    assign st_data   = q.st_data;

endmodule
